// File: rtl/time_reader.sv
// time_reader: captures a coherent snapshot of the live time counters and streams it out as BCD digits.
//
// Streams six digits (HH MM SS), or four digits (HH MM) when SKIP_SECONDS=1, over a valid/ready handshake.
// Optional feature: define TIME_READ_12H_EN to send the hours in 12-hour format and to latch pm_flag.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   rd_req      in   capture-and-send request, sampled only while idle
//   q_seconds   in   [5:0] live seconds
//   q_minutes   in   [5:0] live minutes
//   q_hours     in   [4:0] live hours (0-23)
//   digit       out  [3:0] current BCD digit
//   digit_idx   out  [2:0] digit position, 5 = hours tens ... 0 = seconds units
//   digit_valid out  digit/digit_idx await transfer
//   digit_ready in   sink accepts the digit
//   busy        out  readout in progress
//   rd_done     out  one-cycle pulse after the last transfer
//   pm_flag     out  PM indicator of the captured time
module time_reader #(
    parameter int SKIP_SECONDS = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic [5:0] q_seconds,
    input  logic [5:0] q_minutes,
    input  logic [4:0] q_hours,
    output logic [3:0] digit,
    output logic [2:0] digit_idx,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       busy,
    output logic       rd_done,
    output logic       pm_flag
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [2:0] LAST_IDX = (SKIP_SECONDS != 0) ? 3'd2 : 3'd0;

    state_t     r_state, w_next;
    logic [5:0] r_sec, r_min;
    logic [4:0] r_hr;
    logic [2:0] r_idx;
    logic [5:0] w_hr, w_val;
    logic       w_xfer, w_last, w_cap;

    assign w_cap  = (r_state == IDLE) && rd_req;
    assign w_xfer = digit_valid && digit_ready;
    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = rd_req ? SEND : IDLE;
            SEND:    w_next = (w_xfer && w_last) ? DONE : SEND;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // All three counters are latched on the same edge so a rollover cannot tear the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec <= '0;
            r_min <= '0;
            r_hr  <= '0;
            r_idx <= '0;
        end else if (w_cap) begin
            r_sec <= q_seconds;
            r_min <= q_minutes;
            r_hr  <= q_hours;
            r_idx <= 3'd5;
        end else if (w_xfer && !w_last) begin
            r_idx <= r_idx - 3'd1;
        end
    end

`ifdef TIME_READ_12H_EN
    logic r_pm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_pm <= 1'b0;
        else if (w_cap) r_pm <= (q_hours >= 5'd12);
    end

    assign pm_flag = r_pm;
    assign w_hr    = (r_hr == 5'd0) ? 6'd12 : (r_hr > 5'd12) ? {1'b0, r_hr - 5'd12} : {1'b0, r_hr};
`else
    assign pm_flag = 1'b0;
    assign w_hr    = {1'b0, r_hr};
`endif

    // idx[2:1] selects the field (2 = hours, 1 = minutes, 0 = seconds); odd positions carry the tens digit.
    assign w_val       = (r_idx[2:1] == 2'd2) ? w_hr : (r_idx[2:1] == 2'd1) ? r_min : r_sec;
    assign digit_valid = (r_state == SEND);
    assign busy        = (r_state == SEND);
    assign rd_done     = (r_state == DONE);
    assign digit       = !digit_valid ? 4'd0 : r_idx[0] ? 4'(w_val / 6'd10) : 4'(w_val % 6'd10);
    assign digit_idx   = digit_valid ? r_idx : 3'd0;
endmodule

// File: tb/tb_time_reader.sv
// tb_time_reader: directed self-checking bench for time_reader.
module tb_time_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rd_req = 1'b0;
    logic [5:0] q_seconds = '0;
    logic [5:0] q_minutes = '0;
    logic [4:0] q_hours = '0;
    logic [3:0] digit;
    logic [2:0] digit_idx;
    logic       digit_valid;
    logic       digit_ready = 1'b1;
    logic       busy;
    logic       rd_done;
    logic       pm_flag;
    int         n_checks = 0;
    int         n_errors = 0;

`ifdef TIME_READ_12H_EN
    localparam logic [23:0] E_BASIC = 24'h010742;
    localparam logic        P_BASIC = 1'b1;
    localparam logic [23:0] E_ROLL  = 24'h115959;
    localparam logic        P_ROLL  = 1'b1;
    localparam logic [23:0] E_H0    = 24'h123000;
    localparam logic [23:0] E_H15   = 24'h032005;
    localparam logic        P_H15   = 1'b1;
`else
    localparam logic [23:0] E_BASIC = 24'h130742;
    localparam logic        P_BASIC = 1'b0;
    localparam logic [23:0] E_ROLL  = 24'h235959;
    localparam logic        P_ROLL  = 1'b0;
    localparam logic [23:0] E_H0    = 24'h003000;
    localparam logic [23:0] E_H15   = 24'h152005;
    localparam logic        P_H15   = 1'b0;
`endif

    time_reader dut (
        .clk(clk), .reset(reset), .rd_req(rd_req),
        .q_seconds(q_seconds), .q_minutes(q_minutes), .q_hours(q_hours),
        .digit(digit), .digit_idx(digit_idx), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .busy(busy), .rd_done(rd_done), .pm_flag(pm_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captures h:m:s, then moves the live inputs to 00:00:00 so any leak from them shows up in the digits.
    // stall = index on which the sink withholds ready for five cycles (7 = never); hold keeps rd_req high.
    task automatic readout(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                           input logic [23:0] e, input logic pm, input int stall, input bit hold);
        q_hours = h;
        q_minutes = m;
        q_seconds = s;
        rd_req = 1'b1;
        digit_ready = 1'b1;
        tick();
        q_hours = '0;
        q_minutes = '0;
        q_seconds = '0;
        if (!hold) rd_req = 1'b0;
        check({tag, "_pm"}, 32'(pm_flag), 32'(pm));
        for (int i = 0; i < 6; i++) begin
            check({tag, "_valid"}, 32'(digit_valid), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_idx"}, 32'(digit_idx), 32'(5 - i));
            check({tag, "_digit"}, 32'(digit), 32'(e[23 - 4 * i -: 4]));
            if (5 - i == stall) begin
                digit_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check({tag, "_stall_valid"}, 32'(digit_valid), 32'd1);
                    check({tag, "_stall_idx"}, 32'(digit_idx), 32'(5 - i));
                    check({tag, "_stall_digit"}, 32'(digit), 32'(e[23 - 4 * i -: 4]));
                end
                digit_ready = 1'b1;
            end
            tick();
        end
        check({tag, "_done"}, 32'(rd_done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_valid"}, 32'(digit_valid), 32'd0);
        check({tag, "_done_pm"}, 32'(pm_flag), 32'(pm));
        tick();
        check({tag, "_idle_done"}, 32'(rd_done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(digit_valid), 32'd0);
        rd_req = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(rd_done), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_pm", 32'(pm_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        readout("basic", 5'd13, 6'd7, 6'd42, E_BASIC, P_BASIC, 7, 1'b0);
        readout("stall", 5'd8, 6'd25, 6'd36, 24'h082536, 1'b0, 3, 1'b0);
        readout("roll", 5'd23, 6'd59, 6'd59, E_ROLL, P_ROLL, 7, 1'b0);
        readout("hold", 5'd10, 6'd45, 6'd19, 24'h104519, 1'b0, 7, 1'b1);
        q_hours = 5'd13;
        q_minutes = 6'd7;
        q_seconds = 6'd42;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(digit_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(rd_done), 32'd0);
        check("arst_digit", 32'(digit), 32'd0);
        check("arst_idx", 32'(digit_idx), 32'd0);
        check("arst_pm", 32'(pm_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            tick();
            check("arst_no_done", 32'(rd_done), 32'd0);
            check("arst_no_busy", 32'(busy), 32'd0);
        end
        readout("post_rst", 5'd13, 6'd7, 6'd42, E_BASIC, P_BASIC, 7, 1'b0);
        readout("h0", 5'd0, 6'd30, 6'd0, E_H0, 1'b0, 7, 1'b0);
        readout("h15", 5'd15, 6'd20, 6'd5, E_H15, P_H15, 7, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/time_reader.md
TIME_READER -- requirements
Module: time_reader

Interface
REQ-001 SHALL have parameter SKIP_SECONDS, default 0; 1 = send only four digits (hours, minutes), 0 = send six digits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rd_req  input  1  request to capture and send the current time; sampled only in IDLE.
REQ-005 SHALL have port q_seconds  input  6  live seconds count (binary).
REQ-006 SHALL have port q_minutes  input  6  live minutes count (binary).
REQ-007 SHALL have port q_hours  input  5  live hours count (binary, 0-23).
REQ-008 SHALL have port digit  output  4  current BCD digit.
REQ-009 SHALL have port digit_idx  output  3  position of digit: 5 = hours tens ... 0 = seconds units.
REQ-010 SHALL have port digit_valid  output  1  digit/digit_idx hold a digit awaiting transfer.
REQ-011 SHALL have port digit_ready  input  1  sink accepts digit; transfer occurs on a rising edge where digit_valid and digit_ready are both 1.
REQ-012 SHALL have port busy  output  1  a readout is in progress.
REQ-013 SHALL have port rd_done  output  1  one-cycle pulse after the last digit transfer.
REQ-014 SHALL have port pm_flag  output  1  PM indicator of the captured time.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, DONE.
REQ-016 IDLE: on a rising edge with rd_req=1, SHALL latch q_seconds, q_minutes and q_hours into snapshot registers on that same edge and go to SEND; with rd_req=0, remain in IDLE.
REQ-017 Snapshot SHALL be captured from all three counters on the same edge, so it is coherent across a rollover such as 23:59:59 -> 00:00:00.
REQ-018 In SEND, digit_valid and busy SHALL be 1, starting the cycle after the capture edge (latency 1).
REQ-019 Digit order SHALL be idx 5,4,3,2,1,0 (HH tens, HH units, MM tens, MM units, SS tens, SS units); with SKIP_SECONDS=1, the order SHALL be 5,4,3,2.
REQ-020 Each digit SHALL be tens = value div 10 and units = value mod 10, computed from the snapshot for values 0-63.
REQ-021 While digit_valid=1 and digit_ready=0, digit and digit_idx SHALL be held stable.
REQ-022 On each transfer edge, the next digit SHALL be presented in the following cycle; digit_valid SHALL stay 1 with no gap cycle.
REQ-023 On transfer of the last digit, the FSM SHALL go to DONE; in DONE, rd_done=1, busy=0 and digit_valid=0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 rd_req SHALL be ignored in SEND and DONE, with no queueing.
REQ-025 Snapshot and pm_flag SHALL remain unchanged until the next capture.
REQ-026 Changes on the live counter inputs during SEND SHALL NOT affect the transmitted digits.

Reset
REQ-027 Asserting reset at any time, including mid-readout, SHALL immediately force: state IDLE, digit_valid=0, busy=0, rd_done=0, digit=0, digit_idx=0, pm_flag=0, snapshot=0.
REQ-028 A readout interrupted by reset SHALL be abandoned, with no rd_done pulse.
REQ-029 The first capture SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-030 With macro TIME_READ_12H_EN defined, the transmitted hours SHALL be 12-hour format: 0 -> 12, 1-12 unchanged, 13-23 -> 1-11.
REQ-031 With macro TIME_READ_12H_EN defined, pm_flag SHALL be latched at capture as (q_hours >= 12).
REQ-032 Without TIME_READ_12H_EN, hours SHALL be sent as the raw 0-23 value and pm_flag SHALL be constant 0.

Verification
REQ-033 Bench SHALL cover: time 13:07:42, rd_req pulse, digit_ready=1 -> six consecutive valid cycles, digits 1,3,0,7,4,2 with idx 5..0, then rd_done pulse.
REQ-034 Bench SHALL cover: digit_ready=0 for 5 cycles on idx 3 -> digit/idx held stable, no advance, then transfer resumes in order.
REQ-035 Bench SHALL cover: capture at 23:59:59 with inputs rolling to 00:00:00 the next cycle -> digits 2,3,5,9,5,9 sent.
REQ-036 Bench SHALL cover: rd_req held high during SEND -> exactly one readout; a new capture only after DONE.
REQ-037 Bench SHALL cover: reset asserted after the third transfer -> outputs zero immediately, no rd_done; the next rd_req works normally.
REQ-038 Bench SHALL cover: TIME_READ_12H_EN defined, hours 0 and 15 -> hours digits 1,2 with pm_flag=0, and 0,3 with pm_flag=1.
